conv_post_proc: RTL and testbench
=================================

Name: conv_post_proc

Overview:
Multi-input-channel output stage for the LeNet conv engine. Consumes a stream of signed PE-array partial sums, accumulates them across cfg_cin input channels per output pixel, adds bias, requantizes to DATA_WIDTH, and optionally applies ReLU and 2x2/stride-2 max-pool. Sits between the PE array accumulator output and the feature-map write path, with valid/ready handshakes on both sides.

Parameters:
ACC_WIDTH, 26, signed partial-sum width from the PE array
DATA_WIDTH, 8, signed output activation width
BIAS_WIDTH, 16, signed bias width
MAX_CIN, 16, maximum input channels per output pixel
MAX_DIM, 32, maximum feature-map row width and height (sizes the pool line buffer at MAX_DIM/2 entries)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; latches all cfg_* and begins a frame (IDLE only)
cfg_cin  input  clog2(MAX_CIN+1)  input channels per pixel
cfg_width  input  clog2(MAX_DIM+1)  conv output width W
cfg_height  input  clog2(MAX_DIM+1)  conv output height H
cfg_bias  input  BIAS_WIDTH  signed bias
cfg_shift  input  5  requantize right-shift amount
cfg_relu_en  input  1  enable ReLU
cfg_pool_en  input  1  enable 2x2 max-pool
in_valid  input  1  partial sum valid
in_ready  output  1  partial sum accepted when in_valid & in_ready
in_data  input  ACC_WIDTH  signed partial sum
out_valid  output  1  output activation valid
out_ready  input  1  downstream accept
out_data  output  DATA_WIDTH  signed activation
out_last  output  1  marks final output of frame
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset: in_ready, out_valid, out_data, out_last, busy, done = 0; all counters, accumulator and pipeline valids cleared; state IDLE. Reset mid-frame aborts; line buffer contents irrelevant.
- FSM: IDLE -(start)-> RUN -(last beat of frame accepted)-> DRAIN -(pipeline empty, last output taken)-> DONE (done=1, one cycle) -> IDLE. start outside IDLE ignored.
- Degenerate config: cfg_cin, cfg_width or cfg_height = 0, or pool_en with W<2 or H<2: start goes IDLE->DONE; no outputs, no input accepted.
- Input order: per pixel, cfg_cin consecutive beats; pixels row-major. Counters ch (0..cin-1), col (0..W-1), row (0..H-1) advance on each accepted beat.
- Stall: adv = !out_valid | out_ready. in_ready = (state==RUN) & adv. All three pipeline stages advance only when adv.
- Stage 1: acc <= (ch==0 ? 0 : acc) + in_data; on ch==cin-1 register sum = acc + in_data + sext(bias). Internal width ACC_WIDTH+clog2(MAX_CIN)+1, no overflow.
- Stage 2: if shift>0 add 1<<(shift-1), then arithmetic shift right (round half up); saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; if relu_en, negatives -> 0.
- Stage 3 (pool off): pass-through to out register.
- Stage 3 (pool on), signed compares: even col: hold h=v. Odd col: m=max(h,v); even row: linebuf[col>>1]<=m, no output; odd row: emit max(linebuf[col>>1], m). Odd W: last column dropped; odd H: last row dropped (still consumed).
- Latency: out_valid rises 3 clk edges after the edge accepting a pixel's last-channel beat (pool off, or pooled output pixel), absent stall.
- out_data/out_valid/out_last held stable while out_valid & !out_ready.
- out_last: on pixel (H-1,W-1) (pool off) or pooled pixel (2*floor(H/2)-1, 2*floor(W/2)-1).
- busy = state != IDLE.

Test Plan:
1. pool off, relu off, cin=1, W=H=2, bias=0, shift=0; inputs 5,-3,200,-200 -> outputs 5,-3,127,-128, out_last on 4th, done pulse one cycle later or after.
2. cin=3, W=H=1, bias=3, shift=2; beats 10,20,7 -> out 10; rerun with -10,-1,0, bias=0 -> out -3; out_valid 3 edges after final beat.
3. relu on, pool on, W=4, H=2; row0 1,5,-2,3, row1 4,0,9,-7 -> outputs 5,9; out_last on 9.
4. Test 1 with out_ready low 5 cycles while out_valid high -> out_data stable, in_ready low, exactly 4 outputs, no loss/duplication.
5. pool on, W=H=3, values 1..9 -> single output 5 with out_last; all 9 beats accepted; done pulses.
6. Assert rst_n low mid-frame of test 3 -> all outputs 0, IDLE; new start with test 1 config gives test 1 results.

Source files
------------

// File: rtl/conv_post_proc.sv
// Conv engine output stage: sums partial sums across input channels, adds bias,
// requantizes to DATA_WIDTH and applies optional ReLU and 2x2/stride-2 max-pool.
module conv_post_proc #(
  parameter int ACC_WIDTH  = 26,
  parameter int DATA_WIDTH = 8,
  parameter int BIAS_WIDTH = 16,
  parameter int MAX_CIN    = 16,
  parameter int MAX_DIM    = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_CIN+1)-1:0]   cfg_cin,
  input  logic [$clog2(MAX_DIM+1)-1:0]   cfg_width,
  input  logic [$clog2(MAX_DIM+1)-1:0]   cfg_height,
  input  logic [BIAS_WIDTH-1:0]          cfg_bias,
  input  logic [4:0]                     cfg_shift,
  input  logic                           cfg_relu_en,
  input  logic                           cfg_pool_en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ACC_WIDTH-1:0]           in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int CIN_W    = $clog2(MAX_CIN + 1);
  localparam int DIM_W    = $clog2(MAX_DIM + 1);
  localparam int SUM_W    = ACC_WIDTH + $clog2(MAX_CIN) + 1;
  localparam int RND_W    = SUM_W + 1;
  localparam int LB_DEPTH = MAX_DIM / 2;
  localparam int LB_AW    = $clog2(LB_DEPTH);

  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [CIN_W-1:0]             cin_q;
  logic [DIM_W-1:0]             width_q, height_q;
  logic signed [BIAS_WIDTH-1:0] bias_q;
  logic [4:0]                   shift_q;
  logic                         relu_q, pool_q;

  logic [CIN_W-1:0] ch_q;
  logic [DIM_W-1:0] col_q, row_q;

  logic adv, in_fire, start_ok, cfg_degenerate;
  logic last_ch, last_col, last_row, last_beat, pipe_empty;

  logic signed [SUM_W-1:0] acc_q, in_ext, bias_ext, acc_next;
  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic [DIM_W-1:0]        s1_row, s1_col;

  logic signed [RND_W-1:0] rnd_add, rounded, shifted;
  logic                    s2_valid;
  logic signed [RND_W-1:0] s2_val;
  logic [DIM_W-1:0]        s2_row, s2_col;

  logic signed [DATA_WIDTH-1:0] sat;
  logic                         s3_valid;
  logic signed [DATA_WIDTH-1:0] s3_val;
  logic [DIM_W-1:0]             s3_row, s3_col;

  logic signed [DATA_WIDTH-1:0] h_q, pair_max, lb_rd, quad_max;
  logic signed [DATA_WIDTH-1:0] linebuf [LB_DEPTH];
  logic [LB_AW-1:0]             lb_idx;
  logic [DIM_W-1:0]             pool_last_row, pool_last_col;
  logic                         lb_we;

  // ---------------------------------------------------------------- control
  assign adv      = !out_valid || out_ready;
  assign in_ready = (state_q == RUN) && adv;
  assign in_fire  = in_valid && in_ready;
  assign start_ok = (state_q == IDLE) && start;

  assign cfg_degenerate = (cfg_cin == '0) || (cfg_width == '0) || (cfg_height == '0) ||
                          (cfg_pool_en && ((cfg_width < DIM_W'(2)) || (cfg_height < DIM_W'(2))));

  assign last_ch    = (ch_q == cin_q - CIN_W'(1));
  assign last_col   = (col_q == width_q - DIM_W'(1));
  assign last_row   = (row_q == height_q - DIM_W'(1));
  assign last_beat  = last_ch && last_col && last_row;
  assign pipe_empty = !s1_valid && !s2_valid && !s3_valid && !out_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = cfg_degenerate ? DONE : RUN;
      RUN:     if (in_fire && last_beat) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cin_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      bias_q   <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      pool_q   <= 1'b0;
    end else if (start_ok) begin
      cin_q    <= cfg_cin;
      width_q  <= cfg_width;
      height_q <= cfg_height;
      bias_q   <= cfg_bias;
      shift_q  <= cfg_shift;
      relu_q   <= cfg_relu_en;
      pool_q   <= cfg_pool_en;
    end
  end

  // Channel / column / row position of the next beat to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (start_ok) begin
      ch_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (in_fire) begin
      if (last_ch) begin
        ch_q <= '0;
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end else begin
        ch_q <= ch_q + CIN_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- stage 1
  assign in_ext   = {{(SUM_W - ACC_WIDTH){in_data[ACC_WIDTH-1]}}, in_data};
  assign bias_ext = {{(SUM_W - BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q};
  assign acc_next = ((ch_q == '0) ? '0 : acc_q) + in_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
    end else if (adv) begin
      s1_valid <= in_fire && last_ch;
      if (in_fire) begin
        acc_q <= acc_next;
        if (last_ch) begin
          s1_sum <= acc_next + bias_ext;
          s1_row <= row_q;
          s1_col <= col_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  // Round half up: add half an LSB of the result before the arithmetic shift.
  assign rnd_add = (shift_q != 5'd0) ? (RND_W'(1) << (shift_q - 5'd1)) : '0;
  assign rounded = {s1_sum[SUM_W-1], s1_sum} + rnd_add;
  assign shifted = rounded >>> shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_val   <= '0;
      s2_row   <= '0;
      s2_col   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_val   <= shifted;
      s2_row   <= s1_row;
      s2_col   <= s1_col;
    end
  end

  always_comb begin
    sat = s2_val[DATA_WIDTH-1:0];
    if (s2_val > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (s2_val < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
    if (relu_q && sat[DATA_WIDTH-1]) sat = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_val   <= '0;
      s3_row   <= '0;
      s3_col   <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_val   <= sat;
      s3_row   <= s2_row;
      s3_col   <= s2_col;
    end
  end

  // ---------------------------------------------------------------- stage 3
  assign lb_idx        = s3_col[LB_AW:1];
  assign lb_rd         = linebuf[lb_idx];
  assign pair_max      = (h_q > s3_val) ? h_q : s3_val;
  assign quad_max      = (lb_rd > pair_max) ? lb_rd : pair_max;
  assign pool_last_row = {height_q[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign pool_last_col = {width_q[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign lb_we         = adv && s3_valid && pool_q && s3_col[0] && !s3_row[0];

  // NOTE: the line buffer is storage, not control state: it has no reset, and
  // every entry is written on an even row before an odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_idx] <= pair_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      h_q       <= '0;
    end else if (adv) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (s3_valid) begin
        if (!pool_q) begin
          out_valid <= 1'b1;
          out_data  <= s3_val;
          out_last  <= (s3_row == height_q - DIM_W'(1)) && (s3_col == width_q - DIM_W'(1));
        end else if (!s3_col[0]) begin
          h_q <= s3_val;
        end else if (s3_row[0]) begin
          out_valid <= 1'b1;
          out_data  <= quad_max;
          out_last  <= (s3_row == pool_last_row) && (s3_col == pool_last_col);
        end
      end
    end
  end

  // ---------------------------------------------------------------- checks
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_last));
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);
  a_no_accept_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready |-> adv);

endmodule

// File: tb/tb_conv_post_proc.sv
// Self-checking bench for conv_post_proc: directed vector table, stall/latency/reset
// sequences, and randomized frames against a frame-level reference model.
module tb_conv_post_proc;

  localparam int MAX_DIM = 32;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [4:0]  cfg_cin;
  logic [5:0]  cfg_width, cfg_height;
  logic [15:0] cfg_bias;
  logic [4:0]  cfg_shift;
  logic        cfg_relu_en, cfg_pool_en;
  logic        in_valid, in_ready;
  logic [25:0] in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        out_last, busy, done;

  always #5 clk = ~clk;

  conv_post_proc dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_cin(cfg_cin), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .cfg_relu_en(cfg_relu_en), .cfg_pool_en(cfg_pool_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct packed {
    int cin, w, h, bias, shift;
    bit relu, pool;
  } cfg_t;

  // mode: 0 free-running, 1 random back-pressure, 2 hold out_ready low 5 cycles, 3 latency
  typedef struct packed {
    cfg_t              cfg;
    int                nb, nacc, nexp, mode;
    logic [8:0][31:0]  b;
    logic [3:0][31:0]  e;
  } vec_t;

  typedef int b9_t[9];
  typedef int e4_t[4];

  vec_t tbl[8];
  int   ntbl = 0;
  int   errors = 0, checks = 0;
  int   beats_q[$];
  int   expd_q[$];
  bit   expl_q[$];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input cfg_t c, input int nb, input int nacc, input int nexp, input int mode,
                         input b9_t b, input e4_t e);
    vec_t v;
    v.cfg = c; v.nb = nb; v.nacc = nacc; v.nexp = nexp; v.mode = mode;
    for (int j = 0; j < 9; j++) v.b[j] = b[j];
    for (int j = 0; j < 4; j++) v.e[j] = e[j];
    tbl[ntbl] = v;
    ntbl++;
  endtask

  // Frame-level reference: whole-pixel sums, integer rounding, then a 2x2 window max.
  function automatic void model(input cfg_t c);
    int     act [MAX_DIM][MAX_DIM];
    longint s, v;
    int     m;
    expd_q.delete();
    expl_q.delete();
    if (c.cin == 0 || c.w == 0 || c.h == 0 || (c.pool && (c.w < 2 || c.h < 2))) return;
    for (int r = 0; r < c.h; r++)
      for (int x = 0; x < c.w; x++) begin
        s = c.bias;
        for (int k = 0; k < c.cin; k++) s += beats_q[(r * c.w + x) * c.cin + k];
        v = (c.shift > 0) ? ((s + (longint'(1) <<< (c.shift - 1))) >>> c.shift) : s;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        if (c.relu && v < 0) v = 0;
        act[r][x] = int'(v);
      end
    if (!c.pool) begin
      for (int r = 0; r < c.h; r++)
        for (int x = 0; x < c.w; x++) begin
          expd_q.push_back(act[r][x]);
          expl_q.push_back(r == c.h - 1 && x == c.w - 1);
        end
    end else begin
      for (int pr = 0; pr < c.h / 2; pr++)
        for (int pc = 0; pc < c.w / 2; pc++) begin
          m = act[2*pr][2*pc];
          if (act[2*pr][2*pc+1] > m)   m = act[2*pr][2*pc+1];
          if (act[2*pr+1][2*pc] > m)   m = act[2*pr+1][2*pc];
          if (act[2*pr+1][2*pc+1] > m) m = act[2*pr+1][2*pc+1];
          expd_q.push_back(m);
          expl_q.push_back(pr == c.h / 2 - 1 && pc == c.w / 2 - 1);
        end
    end
  endfunction

  task automatic pulse_start(input cfg_t c);
    @(negedge clk);
    cfg_cin = 5'(c.cin); cfg_width = 6'(c.w); cfg_height = 6'(c.h);
    cfg_bias = 16'(c.bias); cfg_shift = 5'(c.shift);
    cfg_relu_en = c.relu; cfg_pool_en = c.pool;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams beats_q in, checks every output against expd_q/expl_q, waits for done.
  task automatic run_frame(input cfg_t c, input int nacc, input int mode, input string tag);
    int         bi = 0, cyc = 0, nout = 0, nexp, last_fire = -1, first_ov = -1, hold_left = 0;
    bit         hold_started = 0, got_done = 0;
    int         d;
    bit         l;
    logic [7:0] held = '0;
    nexp = expd_q.size();
    pulse_start(c);
    check({tag, "_busy"}, busy, 1);
    while (!got_done && cyc < 3000) begin
      if (done) begin
        got_done = 1;
      end else begin
        if (hold_left > 0) begin
          check({tag, "_hold_data"}, $signed(out_data), $signed(held));
          check({tag, "_hold_valid"}, out_valid, 1);
          hold_left--;
        end
        if (mode == 2 && !hold_started && out_valid) begin
          hold_started = 1;
          hold_left = 5;
          held = out_data;
        end
        if (hold_left > 0)  out_ready = 1'b0;
        else if (mode == 1) out_ready = ($urandom_range(3) != 0);
        else                out_ready = 1'b1;
        in_valid = (bi < beats_q.size()) && (mode != 1 || $urandom_range(4) != 0);
        in_data  = in_valid ? 26'(beats_q[bi]) : '0;
        #1;
        if (hold_left > 0) check({tag, "_hold_in_ready"}, in_ready, 0);
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) begin
          if (expd_q.size() == 0) begin
            check({tag, "_extra_output"}, $signed(out_data), 9999);
          end else begin
            d = expd_q.pop_front();
            l = expl_q.pop_front();
            check($sformatf("%s_data%0d", tag, nout), $signed(out_data), d);
            check($sformatf("%s_last%0d", tag, nout), out_last, l);
          end
          nout++;
        end
        if (in_valid && in_ready) begin
          bi++;
          if (bi == beats_q.size()) last_fire = cyc;
        end
        cyc++;
        @(negedge clk);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done_seen"}, got_done, 1);
    check({tag, "_accepted"}, bi, nacc);
    check({tag, "_out_count"}, nout, nexp);
    if (mode == 3) check({tag, "_latency_edges"}, first_ov - last_fire - 1, 3);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  task automatic load_vec(input int i);
    beats_q.delete(); expd_q.delete(); expl_q.delete();
    for (int j = 0; j < tbl[i].nb; j++) beats_q.push_back($signed(tbl[i].b[j]));
    for (int j = 0; j < tbl[i].nexp; j++) begin
      expd_q.push_back($signed(tbl[i].e[j]));
      expl_q.push_back(j == tbl[i].nexp - 1);
    end
  endtask

  initial begin
    cfg_t c;
    int   bi;

    add_vec(cfg_t'{1, 2, 2, 0, 0, 1'b0, 1'b0}, 4, 4, 4, 0,
            b9_t'{5, -3, 200, -200, 0, 0, 0, 0, 0}, e4_t'{5, -3, 127, -128});
    add_vec(cfg_t'{3, 1, 1, 3, 2, 1'b0, 1'b0}, 3, 3, 1, 3,
            b9_t'{10, 20, 7, 0, 0, 0, 0, 0, 0}, e4_t'{10, 0, 0, 0});
    add_vec(cfg_t'{3, 1, 1, 0, 2, 1'b0, 1'b0}, 3, 3, 1, 3,
            b9_t'{-10, -1, 0, 0, 0, 0, 0, 0, 0}, e4_t'{-3, 0, 0, 0});
    add_vec(cfg_t'{1, 4, 2, 0, 0, 1'b1, 1'b1}, 8, 8, 2, 1,
            b9_t'{1, 5, -2, 3, 4, 0, 9, -7, 0}, e4_t'{5, 9, 0, 0});
    add_vec(cfg_t'{1, 2, 2, 0, 0, 1'b0, 1'b0}, 4, 4, 4, 2,
            b9_t'{5, -3, 200, -200, 0, 0, 0, 0, 0}, e4_t'{5, -3, 127, -128});
    add_vec(cfg_t'{1, 3, 3, 0, 0, 1'b0, 1'b1}, 9, 9, 1, 0,
            b9_t'{1, 2, 3, 4, 5, 6, 7, 8, 9}, e4_t'{5, 0, 0, 0});
    add_vec(cfg_t'{0, 2, 2, 0, 0, 1'b0, 1'b0}, 4, 0, 0, 0,
            b9_t'{1, 2, 3, 4, 0, 0, 0, 0, 0}, e4_t'{0, 0, 0, 0});
    add_vec(cfg_t'{1, 1, 4, 0, 0, 1'b0, 1'b1}, 4, 0, 0, 0,
            b9_t'{1, 2, 3, 4, 0, 0, 0, 0, 0}, e4_t'{0, 0, 0, 0});

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_cin = '0; cfg_width = '0; cfg_height = '0; cfg_bias = '0; cfg_shift = '0;
    cfg_relu_en = 1'b0; cfg_pool_en = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < ntbl; i++) begin
      load_vec(i);
      run_frame(tbl[i].cfg, tbl[i].nacc, tbl[i].mode, $sformatf("vec%0d", i));
    end

    // Reset while a pooled output is stuck waiting on out_ready.
    load_vec(3);
    c = tbl[3].cfg;
    pulse_start(c);
    out_ready = 1'b0;
    bi = 0;
    for (int k = 0; k < 40 && bi < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 26'(beats_q[bi]);
      #1;
      if (in_ready) bi++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_pre_valid", out_valid, 1);
    check("rst_pre_data", $signed(out_data), 5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_data", out_data, 0);
    check("rst_mid_out_last", out_last, 0);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    load_vec(0);
    run_frame(tbl[0].cfg, tbl[0].nacc, 0, "after_rst");

    for (int t = 0; t < 16; t++) begin
      c.cin   = int'($urandom_range(1, 4));
      c.pool  = $urandom_range(1);
      c.relu  = $urandom_range(1);
      c.w     = int'($urandom_range(c.pool ? 2 : 1, 6));
      c.h     = int'($urandom_range(c.pool ? 2 : 1, 6));
      c.bias  = int'($urandom_range(0, 600)) - 300;
      c.shift = int'($urandom_range(0, 6));
      beats_q.delete();
      for (int n = 0; n < c.cin * c.w * c.h; n++) begin
        if ($urandom_range(9) == 0) beats_q.push_back(int'($urandom_range(0, 33554431)) - 16777216);
        else                        beats_q.push_back(int'($urandom_range(0, 8000)) - 4000);
      end
      model(c);
      run_frame(c, c.cin * c.w * c.h, (t % 4 == 0) ? 0 : 1, $sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
